// File: rtl/cnn_layer_accel_fas_vec_add_seq.sv
// Issue-side sequencer for the FAS vector adder.
//
// Handshake: a source FIFO is popped only on a fire cycle. Fire means the job
// is running, FAS is ready, the result FIFO has room, and every needed source
// FIFO is non-empty. All needed FIFOs are popped together, or none of them is.
// Unneeded FIFOs are never popped. pipe_enable, out_fifo_wren, the pop strobes
// and the add strobes are combinational and all follow fire in the same cycle.
module cnn_layer_accel_fas_vec_add_seq #(
  parameter int C_GRP_CNT_WTH = 16,
  parameter int C_DPTH_WTH    = 16
) (
  input  logic                     clk_FAS,
  input  logic                     rst,
  input  logic                     FAS_rdy_n,
  input  logic                     start,
  input  logic                     cfg_vector_add_pm,
  input  logic                     cfg_vector_add_rm0,
  input  logic                     cfg_vector_add_rm1,
  input  logic                     cfg_vector_add_rm_conv,
  input  logic                     cfg_vector_add_pv,
  input  logic [C_DPTH_WTH-1:0]    krnl1x1_dpth_end_cfg,
  input  logic [C_GRP_CNT_WTH-1:0] cfg_num_grp,
  input  logic                     convMap_fifo_empty,
  input  logic                     partMap_fifo_empty,
  input  logic                     resdMap_fifo_empty,
  input  logic                     prevMap_fifo_empty,
  input  logic                     conv1x1_dwc_fifo_empty,
  input  logic                     out_fifo_full,
  output logic                     convMap_fifo_rden,
  output logic                     partMap_fifo_rden,
  output logic                     resdMap_fifo_rden,
  output logic                     prevMap_fifo_rden,
  output logic                     conv1x1_dwc_fifo_rden,
  output logic                     pipe_enable,
  output logic                     vector_add_pm,
  output logic                     vector_add_rm0,
  output logic                     vector_add_rm1,
  output logic                     vector_add_rm_conv,
  output logic                     vector_add_pv,
  output logic                     out_fifo_wren,
  output logic [C_DPTH_WTH-1:0]    dpth_idx,
  output logic                     busy,
  output logic                     process_cmpl
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [C_DPTH_WTH-1:0]    DPTH_ONE = 1;
  localparam logic [C_GRP_CNT_WTH-1:0] GRP_ONE  = 1;

  // Mode bit order:   {pm, rm0, rm1, rm_conv, pv}
  // Source bit order: {conv, part, resd, prev, dwc}
  logic [1:0]               state_q, state_d;
  logic [4:0]               mode_q, mode_d;
  logic [4:0]               need_q, need_d;
  logic [C_DPTH_WTH-1:0]    end_q, end_d;
  logic [C_DPTH_WTH-1:0]    dpth_q, dpth_d;
  logic [C_GRP_CNT_WTH-1:0] grp_last_q, grp_last_d;
  logic [C_GRP_CNT_WTH-1:0] grp_q, grp_d;

  logic [4:0] cfg_mode;
  logic [4:0] cfg_need;
  logic [4:0] src_empty;
  logic       src_ok;
  logic       fire;
  logic       dpth_wrap;

  assign cfg_mode  = {cfg_vector_add_pm, cfg_vector_add_rm0, cfg_vector_add_rm1,
                      cfg_vector_add_rm_conv, cfg_vector_add_pv};
  assign cfg_need  = {cfg_mode[4] | cfg_mode[3] | cfg_mode[2],
                      cfg_mode[4] | cfg_mode[2],
                      cfg_mode[3] | cfg_mode[2] | cfg_mode[1],
                      cfg_mode[0],
                      cfg_mode[1] | cfg_mode[0]};
  assign src_empty = {convMap_fifo_empty, partMap_fifo_empty, resdMap_fifo_empty,
                      prevMap_fifo_empty, conv1x1_dwc_fifo_empty};

  assign src_ok    = ~|(need_q & src_empty);
  assign fire      = (state_q == ST_RUN) & ~FAS_rdy_n & ~out_fifo_full & src_ok;
  assign dpth_wrap = (dpth_q == end_q);

  // Next-state logic. A FAS-not-ready cycle aborts the job from any state.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    need_d     = need_q;
    end_d      = end_q;
    dpth_d     = dpth_q;
    grp_last_d = grp_last_q;
    grp_d      = grp_q;
    if (FAS_rdy_n) begin
      state_d = ST_IDLE;
      dpth_d  = '0;
      grp_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mode_d     = cfg_mode;
            need_d     = cfg_need;
            end_d      = krnl1x1_dpth_end_cfg;
            // A group count of 0 runs one group.
            grp_last_d = (cfg_num_grp == '0) ? '0 : (cfg_num_grp - GRP_ONE);
            dpth_d     = '0;
            grp_d      = '0;
            state_d    = (|cfg_mode) ? ST_RUN : ST_DONE;
          end
        end
        ST_RUN: begin
          if (fire) begin
            if (dpth_wrap) begin
              dpth_d = '0;
              grp_d  = grp_q + GRP_ONE;
              if (grp_q == grp_last_q) state_d = ST_DONE;
            end else begin
              dpth_d = dpth_q + DPTH_ONE;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk_FAS) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= '0;
      need_q     <= '0;
      end_q      <= '0;
      dpth_q     <= '0;
      grp_last_q <= '0;
      grp_q      <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      need_q     <= need_d;
      end_q      <= end_d;
      dpth_q     <= dpth_d;
      grp_last_q <= grp_last_d;
      grp_q      <= grp_d;
    end
  end

  assign pipe_enable           = fire;
  assign out_fifo_wren         = fire;
  assign convMap_fifo_rden     = fire & need_q[4];
  assign partMap_fifo_rden     = fire & need_q[3];
  assign resdMap_fifo_rden     = fire & need_q[2];
  assign prevMap_fifo_rden     = fire & need_q[1];
  assign conv1x1_dwc_fifo_rden = fire & need_q[0];
  assign vector_add_pm         = fire & mode_q[4];
  assign vector_add_rm0        = fire & mode_q[3];
  assign vector_add_rm1        = fire & mode_q[2];
  assign vector_add_rm_conv    = fire & mode_q[1];
  assign vector_add_pv         = fire & mode_q[0];
  assign dpth_idx              = dpth_q;
  assign busy                  = (state_q != ST_IDLE);
  assign process_cmpl          = (state_q == ST_DONE) & ~FAS_rdy_n;

endmodule

// File: tb/tb_cnn_layer_accel_fas_vec_add_seq.sv
// Directed bench for the FAS vector-add sequencer.
module tb_cnn_layer_accel_fas_vec_add_seq;

  logic        clk_FAS = 1'b0;
  logic        rst = 1'b1;
  logic        FAS_rdy_n = 1'b0;
  logic        start = 1'b0;
  logic        cfg_vector_add_pm = 1'b0, cfg_vector_add_rm0 = 1'b0, cfg_vector_add_rm1 = 1'b0;
  logic        cfg_vector_add_rm_conv = 1'b0, cfg_vector_add_pv = 1'b0;
  logic [15:0] krnl1x1_dpth_end_cfg = '0;
  logic [15:0] cfg_num_grp = '0;
  logic        convMap_fifo_empty = 1'b0, partMap_fifo_empty = 1'b0, resdMap_fifo_empty = 1'b0;
  logic        prevMap_fifo_empty = 1'b0, conv1x1_dwc_fifo_empty = 1'b0;
  logic        out_fifo_full = 1'b0;
  logic        convMap_fifo_rden, partMap_fifo_rden, resdMap_fifo_rden;
  logic        prevMap_fifo_rden, conv1x1_dwc_fifo_rden;
  logic        pipe_enable;
  logic        vector_add_pm, vector_add_rm0, vector_add_rm1, vector_add_rm_conv, vector_add_pv;
  logic        out_fifo_wren;
  logic [15:0] dpth_idx;
  logic        busy, process_cmpl;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q[$];

  logic [4:0] rden_vec, vadd_vec;
  assign rden_vec = {convMap_fifo_rden, partMap_fifo_rden, resdMap_fifo_rden,
                     prevMap_fifo_rden, conv1x1_dwc_fifo_rden};
  assign vadd_vec = {vector_add_pm, vector_add_rm0, vector_add_rm1,
                     vector_add_rm_conv, vector_add_pv};

  localparam logic [4:0] M_PM  = 5'b10000;
  localparam logic [4:0] M_RM0 = 5'b01000;
  localparam logic [4:0] M_RM1 = 5'b00100;
  localparam logic [4:0] M_RMC = 5'b00010;
  localparam logic [4:0] M_PV  = 5'b00001;

  cnn_layer_accel_fas_vec_add_seq dut (
    .clk_FAS(clk_FAS), .rst(rst), .FAS_rdy_n(FAS_rdy_n), .start(start),
    .cfg_vector_add_pm(cfg_vector_add_pm), .cfg_vector_add_rm0(cfg_vector_add_rm0),
    .cfg_vector_add_rm1(cfg_vector_add_rm1), .cfg_vector_add_rm_conv(cfg_vector_add_rm_conv),
    .cfg_vector_add_pv(cfg_vector_add_pv),
    .krnl1x1_dpth_end_cfg(krnl1x1_dpth_end_cfg), .cfg_num_grp(cfg_num_grp),
    .convMap_fifo_empty(convMap_fifo_empty), .partMap_fifo_empty(partMap_fifo_empty),
    .resdMap_fifo_empty(resdMap_fifo_empty), .prevMap_fifo_empty(prevMap_fifo_empty),
    .conv1x1_dwc_fifo_empty(conv1x1_dwc_fifo_empty), .out_fifo_full(out_fifo_full),
    .convMap_fifo_rden(convMap_fifo_rden), .partMap_fifo_rden(partMap_fifo_rden),
    .resdMap_fifo_rden(resdMap_fifo_rden), .prevMap_fifo_rden(prevMap_fifo_rden),
    .conv1x1_dwc_fifo_rden(conv1x1_dwc_fifo_rden), .pipe_enable(pipe_enable),
    .vector_add_pm(vector_add_pm), .vector_add_rm0(vector_add_rm0),
    .vector_add_rm1(vector_add_rm1), .vector_add_rm_conv(vector_add_rm_conv),
    .vector_add_pv(vector_add_pv), .out_fifo_wren(out_fifo_wren),
    .dpth_idx(dpth_idx), .busy(busy), .process_cmpl(process_cmpl)
  );

  // Clock
  always #5 clk_FAS = ~clk_FAS;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk_FAS);
    #1;
  endtask

  // Reference source-need model for a mode vector {pm,rm0,rm1,rm_conv,pv}.
  function automatic logic [4:0] need_of(input logic [4:0] m);
    return {m[4] | m[3] | m[2], m[4] | m[2], m[3] | m[2] | m[1], m[0], m[1] | m[0]};
  endfunction

  task automatic set_mode(input logic [4:0] m);
    {cfg_vector_add_pm, cfg_vector_add_rm0, cfg_vector_add_rm1,
     cfg_vector_add_rm_conv, cfg_vector_add_pv} = m;
  endtask

  // Pulse start with the given config, then scramble cfg to prove it was latched.
  task automatic start_job(input logic [4:0] m, input logic [15:0] end_cfg, input logic [15:0] ngrp);
    set_mode(m);
    krnl1x1_dpth_end_cfg = end_cfg;
    cfg_num_grp = ngrp;
    start = 1'b1;
    tick();
    start = 1'b0;
    set_mode(5'b0);
    krnl1x1_dpth_end_cfg = 16'd7;
    cfg_num_grp = 16'd9;
  endtask

  task automatic push_seq(input int end_cfg, input int ngrp);
    int g = (ngrp == 0) ? 1 : ngrp;
    for (int i = 0; i < g; i++)
      for (int d = 0; d <= end_cfg; d++) exp_q.push_back(16'(d));
  endtask

  // Watch a running job until process_cmpl. kind: 0 none, 1 resd empty,
  // 2 out full, 3 start re-pulsed; active for job cycles s_from..s_to.
  task automatic watch(input string name, input logic [4:0] m, input int exp_fires,
                       input int kind, input int s_from, input int s_to);
    int fires = 0;
    int last_fire = 0;
    bit got = 0;
    bit win;
    for (int c = 1; c <= 300; c++) begin
      win = (kind != 0) && (c >= s_from) && (c <= s_to);
      resdMap_fifo_empty = (kind == 1) && win;
      out_fifo_full      = (kind == 2) && win;
      start              = (kind == 3) && win;
      #1;
      if (process_cmpl) begin
        got = 1;
        check({name, "_cmpl_lat"}, 32'(c), 32'(last_fire + 1));
        check({name, "_cmpl_pipe"}, 32'(pipe_enable), 32'd0);
        check({name, "_cmpl_busy"}, 32'(busy), 32'd1);
        break;
      end
      if (win && (kind == 1 || kind == 2)) begin
        check({name, "_stall_pipe"}, 32'(pipe_enable), 32'd0);
        check({name, "_stall_rden"}, 32'(rden_vec), 32'd0);
        check({name, "_stall_wren"}, 32'(out_fifo_wren), 32'd0);
        if (exp_q.size() > 0) check({name, "_stall_idx"}, 32'(dpth_idx), 32'(exp_q[0]));
      end
      if (pipe_enable) begin
        fires++;
        last_fire = c;
        if (exp_q.size() > 0) check({name, "_idx"}, 32'(dpth_idx), 32'(exp_q.pop_front()));
        else check({name, "_extra_fire"}, 32'(fires), 32'(exp_fires));
        check({name, "_rden"}, 32'(rden_vec), 32'(need_of(m)));
        check({name, "_vadd"}, 32'(vadd_vec), 32'(m));
        check({name, "_wren"}, 32'(out_fifo_wren), 32'd1);
      end
      tick();
    end
    resdMap_fifo_empty = 1'b0;
    out_fifo_full = 1'b0;
    start = 1'b0;
    check({name, "_cmpl_seen"}, 32'(got), 32'd1);
    check({name, "_fires"}, 32'(fires), 32'(exp_fires));
    check({name, "_q_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    tick();
    check({name, "_busy_after"}, 32'(busy), 32'd0);
    check({name, "_cmpl_after"}, 32'(process_cmpl), 32'd0);
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmpl", 32'(process_cmpl), 32'd0);
    check("rst_pipe", 32'(pipe_enable), 32'd0);
    check("rst_rden", 32'(rden_vec), 32'd0);
    check("rst_idx", 32'(dpth_idx), 32'd0);
    rst = 1'b0;
    tick();

    // pm only, 4 depths x 2 groups
    push_seq(3, 2);
    start_job(M_PM, 16'd3, 16'd2);
    watch("pm", M_PM, 8, 0, 0, 0);

    // rm1 with resd FIFO empty on job cycles 2-4
    push_seq(2, 2);
    start_job(M_RM1, 16'd2, 16'd2);
    watch("rm1", M_RM1, 6, 1, 2, 4);

    // pv with one-cycle output-full mid-group
    push_seq(3, 3);
    start_job(M_PV, 16'd3, 16'd3);
    watch("pv", M_PV, 12, 2, 6, 6);

    // Abort with FAS_rdy_n at dpth_idx 2 of a 5-group rm0 job
    start_job(M_RM0, 16'd3, 16'd5);
    check("abort_idx0", 32'(dpth_idx), 32'd0);
    tick();
    check("abort_idx1", 32'(dpth_idx), 32'd1);
    tick();
    check("abort_idx2", 32'(dpth_idx), 32'd2);
    FAS_rdy_n = 1'b1;
    #1;
    check("abort_pipe", 32'(pipe_enable), 32'd0);
    check("abort_rden", 32'(rden_vec), 32'd0);
    tick();
    FAS_rdy_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_idx", 32'(dpth_idx), 32'd0);
    check("abort_cmpl", 32'(process_cmpl), 32'd0);
    tick();
    push_seq(3, 5);
    start_job(M_RM0, 16'd3, 16'd5);
    watch("rerun", M_RM0, 20, 0, 0, 0);

    // Empty job
    start_job(5'b0, 16'd3, 16'd2);
    check("empty_cmpl", 32'(process_cmpl), 32'd1);
    check("empty_pipe", 32'(pipe_enable), 32'd0);
    check("empty_rden", 32'(rden_vec), 32'd0);
    tick();
    check("empty_busy", 32'(busy), 32'd0);
    check("empty_cmpl_off", 32'(process_cmpl), 32'd0);

    // start while busy is ignored (rm_conv, 2 depths x 2 groups)
    push_seq(1, 2);
    start_job(M_RMC, 16'd1, 16'd2);
    watch("restart", M_RMC, 4, 3, 2, 2);

    // Reset mid-run
    start_job(M_PM, 16'd3, 16'd2);
    tick();
    rst = 1'b1;
    tick();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_pipe", 32'(pipe_enable), 32'd0);
    check("midrst_rden", 32'(rden_vec), 32'd0);
    check("midrst_idx", 32'(dpth_idx), 32'd0);
    check("midrst_cmpl", 32'(process_cmpl), 32'd0);
    rst = 1'b0;
    tick();

    // end_cfg=0, num_grp=0: exactly one fire
    push_seq(0, 0);
    start_job(M_PM | M_RM0, 16'd0, 16'd0);
    watch("single", M_PM | M_RM0, 1, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
